// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small byte FIFO fed over valid/ready,
// drained LSB-first onto a registered, idle-high tx line.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    data_in,
  input  logic                          valid_in,
  output logic                          ready_out,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] DEPTH_C  = CNTW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [2:0]      bit_idx_reg, bit_idx_next;
  logic [7:0]      shift_reg, shift_next;
  logic            tx_reg, tx_next;
  logic            busy_reg, busy_next;
  logic [CNTW-1:0] count_reg, count_next;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [7:0]      mem [FIFO_DEPTH];

  logic push, pop, bit_end;

  // ready_out depends on the registered count only, so a same-cycle pop
  // never lets a push into a full FIFO.
  assign ready_out  = (count_reg < DEPTH_C);
  assign push       = valid_in && ready_out;
  assign bit_end    = (bit_cnt_reg == BIT_LAST);
  assign tx         = tx_reg;
  assign busy       = busy_reg;
  assign fifo_count = count_reg;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= data_in;
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    tx_next      = tx_reg;
    pop          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          pop          = 1'b1;
          shift_next   = mem[rd_ptr_reg];
          bit_cnt_next = '0;
          state_next   = START;
          tx_next      = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          bit_cnt_next = '0;
          bit_idx_next = 3'd0;
          state_next   = DATA;
          tx_next      = shift_reg[0];
        end else begin
          bit_cnt_next = bit_cnt_reg + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_cnt_next = '0;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
            tx_next      = shift_reg[bit_idx_reg + 3'd1];
          end
        end else begin
          bit_cnt_next = bit_cnt_reg + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          bit_cnt_next = '0;
          // Chain straight into the next start bit when more data is queued.
          if (count_reg != '0) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr_reg];
            state_next = START;
            tx_next    = 1'b0;
          end else begin
            state_next = IDLE;
            tx_next    = 1'b1;
          end
        end else begin
          bit_cnt_next = bit_cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNTW'(1);
      2'b01:   count_next = count_reg - CNTW'(1);
      default: count_next = count_reg;
    endcase
    busy_next = (state_next != IDLE) || (count_next != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      bit_idx_reg <= 3'd0;
      shift_reg   <= 8'h00;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
      count_reg   <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
      busy_reg    <= busy_next;
      count_reg   <= count_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a 4-clock-per-bit instance for most
// scenarios and a 2-clock-per-bit instance for the minimum bit period.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d4_data = 8'h00, d2_data = 8'h00;
  logic       d4_valid = 1'b0, d2_valid = 1'b0;
  logic       d4_ready, d4_tx, d4_busy;
  logic       d2_ready, d2_tx, d2_busy;
  logic [2:0] d4_count, d2_count;

  int tests = 0;
  int fails = 0;
  logic [7:0] rx_q [$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .data_in(d4_data), .valid_in(d4_valid),
    .ready_out(d4_ready), .tx(d4_tx), .busy(d4_busy), .fifo_count(d4_count));

  uart_tx_fifo #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .data_in(d2_data), .valid_in(d2_valid),
    .ready_out(d2_ready), .tx(d2_tx), .busy(d2_busy), .fifo_count(d2_count));

  // Receiver for dut4: samples mid-bit on falling edges, drops frames hit by reset.
  initial begin : rx_monitor
    logic [7:0] b;
    logic       ab;
    forever begin
      @(negedge clk);
      if (!rst && d4_tx == 1'b0) begin
        ab = 1'b0;
        repeat (2) begin @(negedge clk); if (rst) ab = 1'b1; end
        for (int k = 0; k < 8; k++) begin
          repeat (4) begin @(negedge clk); if (rst) ab = 1'b1; end
          b[k] = d4_tx;
        end
        repeat (4) begin @(negedge clk); if (rst) ab = 1'b1; end
        if (!ab && d4_tx) rx_q.push_back(b);
        @(negedge clk);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  task automatic wait_idle4(input int budget);
    int n = 0;
    while (d4_busy && n < budget) begin tick(); n++; end
    tests++;
    if (d4_busy !== 1'b0) begin
      fails++; $display("FAIL wait_idle: busy=%b required 0 within %0d cycles", d4_busy, budget);
    end
    tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    tests++;
    if ({d4_tx, d4_ready, d4_busy, d4_count} !== 6'b110_000) begin
      fails++; $display("FAIL reset4: tx,ready,busy,count=%b required 110000", {d4_tx, d4_ready, d4_busy, d4_count});
    end
    tests++;
    if ({d2_tx, d2_ready, d2_busy, d2_count} !== 6'b110_000) begin
      fails++; $display("FAIL reset2: tx,ready,busy,count=%b required 110000", {d2_tx, d2_ready, d2_busy, d2_count});
    end
    rst = 1'b0;
    tick(); tick();
    $display("[TB] test_reset done");
  endtask

  task automatic test_single_frame();
    logic [9:0] f;
    logic [3:0] seen;
    f = frame_of(8'hA5);
    rx_q.delete();
    d4_data = 8'hA5; d4_valid = 1'b1;
    tick();
    d4_valid = 1'b0;
    tests++;
    if (d4_count !== 3'd1 || d4_tx !== 1'b1) begin
      fails++; $display("FAIL a5_push: count=%0d tx=%b required 1,1", d4_count, d4_tx);
    end
    tick();
    tests++;
    if (d4_tx !== 1'b0 || d4_count !== 3'd0) begin
      fails++; $display("FAIL a5_start_latency: tx=%b count=%0d required 0,0", d4_tx, d4_count);
    end
    for (int bi = 0; bi < 10; bi++) begin
      for (int c = 0; c < 4; c++) begin
        if (bi != 0 || c != 0) tick();
        seen[c] = d4_tx;
      end
      tests++;
      if (seen !== {4{f[bi]}}) begin
        fails++; $display("FAIL a5_bit%0d: samples=%b required %b", bi, seen, {4{f[bi]}});
      end
    end
    tests++;
    if (d4_busy !== 1'b1) begin
      fails++; $display("FAIL a5_busy_in_stop: busy=%b required 1", d4_busy);
    end
    tick();
    tests++;
    if (d4_busy !== 1'b0 || d4_tx !== 1'b1) begin
      fails++; $display("FAIL a5_end: busy=%b tx=%b required 0,1", d4_busy, d4_tx);
    end
    tests++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
      fails++; $display("FAIL a5_rx: size=%0d byte=%h required 1,a5", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
    tick(); tick();
    $display("[TB] test_single_frame done");
  endtask

  task automatic test_back_to_back();
    logic [9:0]  f0, f1;
    logic [79:0] obs, exp_v;
    logic        busy_low;
    f0 = frame_of(8'h00);
    f1 = frame_of(8'hFF);
    for (int i = 0; i < 80; i++) exp_v[i] = (i < 40) ? f0[i / 4] : f1[(i - 40) / 4];
    rx_q.delete();
    busy_low = 1'b0;
    d4_data = 8'h00; d4_valid = 1'b1;
    tick();
    d4_data = 8'hFF;
    tick();
    d4_valid = 1'b0;
    tests++;
    if (d4_count !== 3'd1) begin
      fails++; $display("FAIL b2b_push_pop_count: count=%0d required 1", d4_count);
    end
    for (int i = 0; i < 80; i++) begin
      if (i != 0) tick();
      obs[i] = d4_tx;
      if (d4_busy !== 1'b1) busy_low = 1'b1;
    end
    tests++;
    if (obs[39:0] !== exp_v[39:0]) begin
      fails++; $display("FAIL b2b_frame0: tx=%h required %h", obs[39:0], exp_v[39:0]);
    end
    tests++;
    if (obs[79:40] !== exp_v[79:40]) begin
      fails++; $display("FAIL b2b_frame1: tx=%h required %h", obs[79:40], exp_v[79:40]);
    end
    tests++;
    if (busy_low !== 1'b0) begin
      fails++; $display("FAIL b2b_busy: busy dropped=%b required 0", busy_low);
    end
    tick();
    tests++;
    if (d4_busy !== 1'b0) begin
      fails++; $display("FAIL b2b_end_busy: busy=%b required 0", d4_busy);
    end
    tests++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h00 || rx_q[1] !== 8'hFF) begin
      fails++; $display("FAIL b2b_rx: size=%0d required 2 bytes 00,ff", rx_q.size());
    end
    tick(); tick();
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_burst();
    int acc = 0;
    rx_q.delete();
    for (int i = 1; i <= 8; i++) begin
      d4_data = 8'(i); d4_valid = 1'b1;
      if (d4_ready) acc++;
      tick();
    end
    d4_valid = 1'b0;
    tests++;
    if (acc != 5) begin
      fails++; $display("FAIL burst_accepted: got %0d required 5", acc);
    end
    tests++;
    if (d4_count !== 3'd4 || d4_ready !== 1'b0) begin
      fails++; $display("FAIL burst_full: count=%0d ready=%b required 4,0", d4_count, d4_ready);
    end
    wait_idle4(400);
    tests++;
    if (rx_q.size() != 5) begin
      fails++; $display("FAIL burst_rx_count: got %0d required 5", rx_q.size());
    end
    for (int j = 0; j < 5; j++) begin
      tests++;
      if (j >= rx_q.size() || rx_q[j] !== 8'(j + 1)) begin
        fails++; $display("FAIL burst_rx_%0d: got %h required %h", j, (j < rx_q.size()) ? rx_q[j] : 8'hxx, 8'(j + 1));
      end
    end
    $display("[TB] test_burst done");
  endtask

  task automatic test_full_refill();
    logic [7:0] nxt = 8'h20;
    int   nacc = 0;
    logic prev_ready = 1'b1, prev_tx = 1'b1, acc_now;
    logic rose = 1'b0, pend = 1'b0;
    logic [2:0] maxc = 3'd0;
    rx_q.delete();
    d4_data = nxt; d4_valid = 1'b1;
    for (int cyc = 0; cyc < 600 && nacc < 8; cyc++) begin
      acc_now = d4_ready;
      tick();
      if (acc_now) begin nacc++; nxt = nxt + 8'd1; d4_data = nxt; end
      if (nacc == 8) d4_valid = 1'b0;
      if (d4_count > maxc) maxc = d4_count;
      if (pend) begin
        pend = 1'b0;
        tests++;
        if (d4_count !== 3'd4) begin
          fails++; $display("FAIL refill_accept: count=%0d required 4", d4_count);
        end
      end
      if (!rose && !prev_ready && d4_ready) begin
        rose = 1'b1;
        pend = 1'b1;
        tests++;
        if (d4_tx !== 1'b0 || prev_tx !== 1'b1 || d4_count !== 3'd3) begin
          fails++; $display("FAIL refill_rise: tx %b->%b count=%0d required 1->0,3", prev_tx, d4_tx, d4_count);
        end
      end
      prev_ready = d4_ready;
      prev_tx    = d4_tx;
    end
    d4_valid = 1'b0;
    tests++;
    if (nacc != 8 || rose !== 1'b1) begin
      fails++; $display("FAIL refill_progress: accepted=%0d rose=%b required 8,1", nacc, rose);
    end
    tests++;
    if (maxc !== 3'd4) begin
      fails++; $display("FAIL refill_max_count: got %0d required 4", maxc);
    end
    wait_idle4(600);
    tests++;
    if (rx_q.size() != 8) begin
      fails++; $display("FAIL refill_rx_count: got %0d required 8", rx_q.size());
    end
    for (int j = 0; j < 8 && j < rx_q.size(); j++) begin
      tests++;
      if (rx_q[j] !== 8'h20 + 8'(j)) begin
        fails++; $display("FAIL refill_rx_%0d: got %h required %h", j, rx_q[j], 8'h20 + 8'(j));
      end
    end
    $display("[TB] test_full_refill done");
  endtask

  task automatic test_reset_mid_frame();
    logic bad = 1'b0;
    rx_q.delete();
    d4_data = 8'h55; d4_valid = 1'b1;
    tick();
    d4_data = 8'h11;
    tick();
    d4_data = 8'h22;
    tick();
    d4_valid = 1'b0;
    repeat (16) tick();
    tests++;
    if (d4_tx !== 1'b0 || d4_count !== 3'd2) begin
      fails++; $display("FAIL rstmid_pre: tx=%b count=%0d required 0,2", d4_tx, d4_count);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({d4_tx, d4_ready, d4_busy, d4_count} !== 6'b110_000) begin
      fails++; $display("FAIL rstmid_async: tx,ready,busy,count=%b required 110000", {d4_tx, d4_ready, d4_busy, d4_count});
    end
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (d4_tx !== 1'b1 || d4_busy !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad !== 1'b0) begin
      fails++; $display("FAIL rstmid_quiet: activity=%b required 0", bad);
    end
    tests++;
    if (rx_q.size() != 0) begin
      fails++; $display("FAIL rstmid_rx: got %0d bytes required 0", rx_q.size());
    end
    $display("[TB] test_reset_mid_frame done");
  endtask

  task automatic test_min_cpb();
    logic [9:0] f;
    logic [1:0] seen;
    f = frame_of(8'h81);
    d2_data = 8'h81; d2_valid = 1'b1;
    tick();
    d2_valid = 1'b0;
    tick();
    tests++;
    if (d2_tx !== 1'b0) begin
      fails++; $display("FAIL cpb2_start_latency: tx=%b required 0", d2_tx);
    end
    for (int bi = 0; bi < 10; bi++) begin
      for (int c = 0; c < 2; c++) begin
        if (bi != 0 || c != 0) tick();
        seen[c] = d2_tx;
      end
      tests++;
      if (seen !== {2{f[bi]}}) begin
        fails++; $display("FAIL cpb2_bit%0d: samples=%b required %b", bi, seen, {2{f[bi]}});
      end
    end
    tick();
    tests++;
    if (d2_busy !== 1'b0 || d2_tx !== 1'b1) begin
      fails++; $display("FAIL cpb2_end: busy=%b tx=%b required 0,1", d2_busy, d2_tx);
    end
    $display("[TB] test_min_cpb done");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_burst();
    test_full_refill();
    test_reset_mid_frame();
    test_min_cpb();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
